// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture
// Receive side of the servo PWM link. Measures the high time and the
// rise-to-rise period of an asynchronous servo PWM input in whole
// microseconds, range-checks each completed pulse and recovers the
// 10-bit position value x = width - OFFSET_US (clamped to 0..1023).
// Accepted pulses raise sample_valid for one cycle. Rejected pulses raise
// err_range for one cycle. signal_lost stays high until the first accepted
// sample after reset, and is raised again when no rising edge arrives
// within TIMEOUT_US.
module servo_pwm_capture #(
  parameter int CLK_DIV     = 100,
  parameter int OFFSET_US   = 1000,
  parameter int MIN_HIGH_US = 900,
  parameter int MAX_HIGH_US = 2100,
  parameter int TIMEOUT_US  = 6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [11:0] width_us,
  output logic [12:0] period_us,
  output logic [9:0]  x_out,
  output logic        sample_valid,
  output logic        err_range,
  output logic        signal_lost
);

  // Prescaler width. A single-bit counter is kept even for CLK_DIV = 1.
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [11:0]       MIN_HI    = 12'(MIN_HIGH_US);
  localparam logic [11:0]       MAX_HI    = 12'(MAX_HIGH_US);
  localparam logic [12:0]       TIMEOUT   = 13'(TIMEOUT_US);
  localparam logic signed [12:0] OFFSET   = 13'(OFFSET_US);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } state_t;

  // Saturating increment for the 12-bit high-time counter
  function automatic logic [11:0] sat_inc12(input logic [11:0] c);
    if (c == 12'hFFF) begin
      sat_inc12 = c;
    end else begin
      sat_inc12 = c + 12'd1;
    end
  endfunction

  // Saturating increment for the 13-bit period counter
  function automatic logic [12:0] sat_inc13(input logic [12:0] c);
    if (c == 13'h1FFF) begin
      sat_inc13 = c;
    end else begin
      sat_inc13 = c + 13'd1;
    end
  endfunction

  // Position value: signed difference from the offset, clamped to 0..1023
  function automatic logic [9:0] clamp_x(input logic [11:0] hi);
    logic signed [12:0] diff;
    diff = $signed({1'b0, hi}) - OFFSET;
    if (diff < 13'sd0) begin
      clamp_x = 10'd0;
    end else if (diff > 13'sd1023) begin
      clamp_x = 10'd1023;
    end else begin
      clamp_x = diff[9:0];
    end
  endfunction

  // Synchroniser, edge history and history-valid tracking
  logic          s1_r;
  logic          s2_r;
  logic          s3_r;
  logic [2:0]    hist_vld_r;
  logic          rise_s;
  logic          fall_s;

  // Prescaler and measurement counters
  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic [11:0]   hi_cnt_r;
  logic [12:0]   per_cnt_r;
  logic [11:0]   hi_hold_r;
  logic [11:0]   hi_nxt_s;
  logic [12:0]   per_nxt_s;

  // FSM
  state_t        state_r;
  state_t        state_s;
  logic          start_s;
  logic          latch_s;
  logic          eval_s;
  logic          timeout_s;
  logic          in_range_s;

  // Bring the async pin into the clk domain; history_valid masks the
  // artificial edge the zeroed synchroniser would show right after reset,
  // so a pin that is already high at reset release is not taken as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r       <= 1'b0;
      s2_r       <= 1'b0;
      s3_r       <= 1'b0;
      hist_vld_r <= 3'b000;
    end else begin
      s1_r       <= pwm_in;
      s2_r       <= s1_r;
      s3_r       <= s2_r;
      hist_vld_r <= {hist_vld_r[1:0], 1'b1};
    end
  end

  assign rise_s = s2_r & ~s3_r & hist_vld_r[2];
  assign fall_s = ~s2_r & s3_r & hist_vld_r[2];

  // Microsecond prescaler, re-phased on every rise so the measurement
  // starts on a tick boundary; free-running across the falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
    end else if (rise_s) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  assign tick_s = (presc_r == PRESC_MAX);

  // Counter values including the tick of the current cycle. A fall or rise
  // that lands on a tick must see that tick, so that a pulse of exactly
  // N*CLK_DIV cycles reads N.
  assign hi_nxt_s  = tick_s ? sat_inc12(hi_cnt_r)  : hi_cnt_r;
  assign per_nxt_s = tick_s ? sat_inc13(per_cnt_r) : per_cnt_r;

  assign in_range_s = (hi_hold_r >= MIN_HI) && (hi_hold_r <= MAX_HI);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and control decode; a rise in LOW beats a timeout in
  // the same cycle.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    latch_s   = 1'b0;
    eval_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          start_s = 1'b1;
          state_s = ST_HIGH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (per_cnt_r >= TIMEOUT) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (fall_s) begin
          latch_s = 1'b1;
          state_s = ST_LOW;
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          eval_s  = 1'b1;
          start_s = 1'b1;
          state_s = ST_HIGH;
        end else if (per_cnt_r >= TIMEOUT) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_LOW;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // High-time and period counters plus the held high time of the last pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_cnt_r  <= 12'd0;
      per_cnt_r <= 13'd0;
      hi_hold_r <= 12'd0;
    end else if (start_s) begin
      hi_cnt_r  <= 12'd0;
      per_cnt_r <= 13'd0;
    end else begin
      if (state_r == ST_HIGH) begin
        hi_cnt_r <= hi_nxt_s;
      end
      if (state_r != ST_IDLE) begin
        per_cnt_r <= per_nxt_s;
      end
      if (latch_s) begin
        hi_hold_r <= hi_nxt_s;
      end
    end
  end

  // Registered results and strobes; rejected pulses leave the last
  // accepted sample and signal_lost untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_us     <= 12'd0;
      period_us    <= 13'd0;
      x_out        <= 10'd0;
      sample_valid <= 1'b0;
      err_range    <= 1'b0;
      signal_lost  <= 1'b1;
    end else begin
      sample_valid <= 1'b0;
      err_range    <= 1'b0;
      if (eval_s && in_range_s) begin
        width_us     <= hi_hold_r;
        period_us    <= per_nxt_s;
        x_out        <= clamp_x(hi_hold_r);
        sample_valid <= 1'b1;
        signal_lost  <= 1'b0;
      end else if (eval_s) begin
        err_range <= 1'b1;
      end else if (timeout_s) begin
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Self-checking bench for servo_pwm_capture: directed table of frames,
// randomized frames against an event-level reference model, and
// hand-written timeout / stuck-high / mid-pulse reset sequences.
module tb_servo_pwm_capture;

  // Shortened time base so long frames stay within a small cycle count
  localparam int CD   = 2;
  localparam int OFF  = 10;
  localparam int MINH = 6;
  localparam int MAXH = 1040;
  localparam int TO   = 1200;

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic [11:0] width_us;
  logic [12:0] period_us;
  logic [9:0]  x_out;
  logic        sample_valid;
  logic        err_range;
  logic        signal_lost;

  servo_pwm_capture #(
    .CLK_DIV    (CD),
    .OFFSET_US  (OFF),
    .MIN_HIGH_US(MINH),
    .MAX_HIGH_US(MAXH),
    .TIMEOUT_US (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .width_us    (width_us),
    .period_us   (period_us),
    .x_out       (x_out),
    .sample_valid(sample_valid),
    .err_range   (err_range),
    .signal_lost (signal_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame: high h us within period p us, and the outputs expected at
  // the strobe slot just after this frame's rising edge.
  typedef struct {
    int h;
    int p;
    bit sv;
    bit er;
    int w;
    int per;
    int x;
    bit lost;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (frame level)
  bit m_have_prev;
  int m_prev_h;
  int m_prev_p;
  int m_w;
  int m_per;
  int m_x;
  bit m_lost;
  int exp_sv_total = 0;
  int exp_er_total = 0;

  // Strobe monitor
  int mon_sv   = 0;
  int mon_er   = 0;
  int mon_both = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) mon_sv++;
      if (err_range) mon_er++;
      if (sample_valid && err_range) mon_both++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_x(input int h);
    int d;
    d = h - OFF;
    if (d < 0) return 0;
    if (d > 1023) return 1023;
    return d;
  endfunction

  function automatic void model_reset();
    m_have_prev = 1'b0;
    m_prev_h = 0;
    m_prev_p = 0;
    m_w = 0;
    m_per = 0;
    m_x = 0;
    m_lost = 1'b1;
  endfunction

  function automatic void model_timeout();
    m_have_prev = 1'b0;
    m_lost = 1'b1;
  endfunction

  // A new rise closes the previous frame: accept or reject it, then the
  // new frame becomes the pending one.
  function automatic vec_t predict(input int h, input int p);
    vec_t v;
    v.h = h;
    v.p = p;
    v.sv = 1'b0;
    v.er = 1'b0;
    if (m_have_prev) begin
      if (m_prev_h >= MINH && m_prev_h <= MAXH) begin
        v.sv = 1'b1;
        m_w = m_prev_h;
        m_per = m_prev_p;
        m_x = ref_x(m_prev_h);
        m_lost = 1'b0;
      end else begin
        v.er = 1'b1;
      end
    end
    m_have_prev = 1'b1;
    m_prev_h = h;
    m_prev_p = p;
    v.w = m_w;
    v.per = m_per;
    v.x = m_x;
    v.lost = m_lost;
    return v;
  endfunction

  task automatic hold(input bit lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // Rising edge at a negedge; strobe must appear exactly 3 clk later.
  task automatic do_rise(input vec_t v);
    pwm_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("strobe_early", int'(sample_valid | err_range), 0);
    @(negedge clk);
    check("sample_valid", int'(sample_valid), int'(v.sv));
    check("err_range", int'(err_range), int'(v.er));
    check("width_us", int'(width_us), v.w);
    check("period_us", int'(period_us), v.per);
    check("x_out", int'(x_out), v.x);
    check("signal_lost", int'(signal_lost), int'(v.lost));
    if (v.sv) exp_sv_total++;
    if (v.er) exp_er_total++;
    @(negedge clk);
    check("strobe_late", int'(sample_valid | err_range), 0);
  endtask

  task automatic run_frame(input vec_t v);
    do_rise(v);
    hold(1'b1, v.h * CD - 4);
    hold(1'b0, (v.p - v.h) * CD);
  endtask

  task automatic check_reset_vals();
    check("rst_width", int'(width_us), 0);
    check("rst_period", int'(period_us), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_sv", int'(sample_valid), 0);
    check("rst_er", int'(err_range), 0);
    check("rst_lost", int'(signal_lost), 1);
  endtask

  vec_t tbl [13];

  initial begin
    vec_t v;
    int h;
    int p;
    int sel;
    int snap;

    tbl[0]  = '{100,  200,  1'b0, 1'b0, 0,    0,    0,    1'b1};
    tbl[1]  = '{150,  300,  1'b1, 1'b0, 100,  200,  90,   1'b0};
    tbl[2]  = '{8,    100,  1'b1, 1'b0, 150,  300,  140,  1'b0};
    tbl[3]  = '{1040, 1100, 1'b1, 1'b0, 8,    100,  0,    1'b0};
    tbl[4]  = '{1033, 1100, 1'b1, 1'b0, 1040, 1100, 1023, 1'b0};
    tbl[5]  = '{1034, 1100, 1'b1, 1'b0, 1033, 1100, 1023, 1'b0};
    tbl[6]  = '{120,  200,  1'b1, 1'b0, 1034, 1100, 1023, 1'b0};
    tbl[7]  = '{5,    100,  1'b1, 1'b0, 120,  200,  110,  1'b0};
    tbl[8]  = '{1041, 1100, 1'b0, 1'b1, 120,  200,  110,  1'b0};
    tbl[9]  = '{6,    50,   1'b0, 1'b1, 120,  200,  110,  1'b0};
    tbl[10] = '{1040, 1150, 1'b1, 1'b0, 6,    50,   0,    1'b0};
    tbl[11] = '{200,  250,  1'b1, 1'b0, 1040, 1150, 1023, 1'b0};
    tbl[12] = '{200,  250,  1'b1, 1'b0, 200,  250,  190,  1'b0};

    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    model_reset();
    hold(1'b0, 10);

    // Directed frames: first rise silent, clamps, range boundaries
    for (int i = 0; i < 13; i++) begin
      void'(predict(tbl[i].h, tbl[i].p));
      run_frame(tbl[i]);
    end

    // Randomized frames against the reference model
    for (int i = 0; i < 12; i++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: h = int'($urandom_range(3, 8));
        1: h = int'($urandom_range(1036, 1045));
        default: h = int'($urandom_range(9, 1035));
      endcase
      p = int'($urandom_range(h + 5, 1150));
      v = predict(h, p);
      run_frame(v);
    end

    // Input held low past the timeout
    v = predict(200, TO + 100);
    do_rise(v);
    hold(1'b1, 200 * CD - 4);
    hold(1'b0, TO * CD - 200 * CD);
    check("lost_before_timeout", int'(signal_lost), int'(m_lost));
    hold(1'b0, 10);
    check("lost_after_timeout", int'(signal_lost), 1);
    check("to_hold_width", int'(width_us), m_w);
    check("to_hold_period", int'(period_us), m_per);
    check("to_hold_x", int'(x_out), m_x);
    model_timeout();
    hold(1'b0, 100);
    v = predict(150, 300);
    run_frame(v);
    v = predict(150, 300);
    run_frame(v);

    // Input stuck high past the timeout, then a lone falling edge
    v = predict(TO + 100, TO + 200);
    do_rise(v);
    hold(1'b1, TO * CD - 4);
    check("stuck_lost_before", int'(signal_lost), int'(m_lost));
    hold(1'b1, 10);
    check("stuck_lost_after", int'(signal_lost), 1);
    model_timeout();
    hold(1'b1, 100);
    snap = mon_sv + mon_er;
    hold(1'b0, 50);
    check("fall_only_strobes", mon_sv + mon_er - snap, 0);
    hold(1'b0, 50);
    v = predict(150, 300);
    run_frame(v);
    v = predict(150, 300);
    run_frame(v);

    // Reset in the middle of a high phase, released while still high
    v = predict(300, 600);
    do_rise(v);
    hold(1'b1, 100 * CD);
    rst = 1'b1;
    hold(1'b1, 3);
    check_reset_vals();
    rst = 1'b0;
    model_reset();
    hold(1'b1, 50 * CD);
    hold(1'b0, 100 * CD);
    v = predict(300, 600);
    run_frame(v);
    v = predict(200, 400);
    run_frame(v);
    hold(1'b0, 20);

    check("sample_valid_count", mon_sv, exp_sv_total);
    check("err_range_count", mon_er, exp_er_total);
    check("strobes_together", mon_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
